// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch queue: state encoding,
// instruction size and the pointer-width helper.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Core-side fetch handshake and instruction-BRAM request/response bus.
// master = the prefetch queue, slave = core plus memory.
interface fetch_prefetch_queue_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
);
  logic                    fetch_valid;
  logic [DATA_WIDTH-1:0]   fetch_instruction;
  logic [ADDRESS_BITS-1:0] fetch_pc;
  logic                    fetch_ready;
  logic                    i_mem_read;
  logic [ADDRESS_BITS-1:0] i_mem_address_in;
  logic [DATA_WIDTH-1:0]   i_mem_data_out;
  logic [ADDRESS_BITS-1:0] i_mem_address_out;
  logic                    i_mem_valid;
  logic                    i_mem_ready;

  modport master (
    output fetch_valid, fetch_instruction, fetch_pc, i_mem_read, i_mem_address_in,
    input  fetch_ready, i_mem_data_out, i_mem_address_out, i_mem_valid, i_mem_ready
  );

  modport slave (
    input  fetch_valid, fetch_instruction, fetch_pc, i_mem_read, i_mem_address_in,
    output fetch_ready, i_mem_data_out, i_mem_address_out, i_mem_valid, i_mem_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer holding fetched {instruction, pc} entries; flush wins over
// push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 4,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (PTR_W+1)'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is left unreset; consumers qualify it with count.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential BRAM reads ahead of the core,
// buffers in-order returns and squashes stale ones after a redirect.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int  DATA_WIDTH   = 32,
  parameter int  ADDRESS_BITS = 32,
  parameter int  DEPTH        = 4,
  localparam int CNT_W        = ptr_width(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] program_address,
  input  logic                    redirect,
  input  logic [ADDRESS_BITS-1:0] redirect_address,
  fetch_prefetch_queue_if.master  bus,
  output logic [CNT_W-1:0]        occupancy,
  output logic                    protocol_error
);

  localparam logic [ADDRESS_BITS-1:0] STEP = ADDRESS_BITS'(INSTR_BYTES);

  function automatic logic [ADDRESS_BITS-1:0] align(input logic [ADDRESS_BITS-1:0] a);
    return a & ~ADDRESS_BITS'(INSTR_BYTES - 1);
  endfunction

  state_t                               state;
  logic [ADDRESS_BITS-1:0]              next_addr;
  logic [ADDRESS_BITS-1:0]              expect_addr;
  logic [CNT_W-1:0]                     outstanding;
  logic [CNT_W-1:0]                     drop_count;
  logic [CNT_W-1:0]                     outstanding_net;
  logic [CNT_W:0]                       in_use;
  logic [DATA_WIDTH+ADDRESS_BITS-1:0]   head;
  logic run, redirect_run, issue, resp_ok, dropping, addr_match, push, pop, violation;

  assign run          = (state == RUN);
  assign redirect_run = run && redirect;
  // Credit rule: buffered plus in-flight never exceeds DEPTH, so a push always fits.
  assign in_use       = {1'b0, occupancy} + {1'b0, outstanding};
  assign issue        = run && bus.i_mem_ready && (in_use < (CNT_W+1)'(DEPTH)) && !redirect;
  assign resp_ok      = bus.i_mem_valid && (outstanding != '0);
  assign dropping     = resp_ok && (drop_count != '0);
  assign addr_match   = (bus.i_mem_address_out == expect_addr);
  assign push         = resp_ok && !dropping && addr_match && !redirect_run;
  assign pop          = bus.fetch_valid && bus.fetch_ready && !redirect_run;
  assign violation    = (bus.i_mem_valid && (outstanding == '0)) ||
                        (resp_ok && !dropping && !addr_match && !redirect_run);
  assign outstanding_net = outstanding - CNT_W'(resp_ok);

  assign bus.i_mem_read        = issue;
  assign bus.i_mem_address_in  = next_addr;
  assign bus.fetch_valid       = (occupancy != '0);
  assign bus.fetch_pc          = bus.fetch_valid ? head[ADDRESS_BITS-1:0] : '0;
  assign bus.fetch_instruction = bus.fetch_valid ? head[DATA_WIDTH+ADDRESS_BITS-1:ADDRESS_BITS] : '0;

  fetch_fifo #(
    .WIDTH (DATA_WIDTH + ADDRESS_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_run),
    .data  ({bus.i_mem_data_out, bus.i_mem_address_out}),
    .head  (head),
    .count (occupancy)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      next_addr      <= '0;
      expect_addr    <= '0;
      outstanding    <= '0;
      drop_count     <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (violation) protocol_error <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            next_addr   <= align(program_address);
            expect_addr <= align(program_address);
          end
        end
        RUN: begin
          if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            next_addr   <= align(redirect_address);
            expect_addr <= align(redirect_address);
            outstanding <= outstanding_net;
            drop_count  <= outstanding_net;
          end else begin
            if (issue)    next_addr   <= next_addr + STEP;
            if (push)     expect_addr <= expect_addr + STEP;
            if (dropping) drop_count  <= drop_count - 1'b1;
            outstanding <= outstanding_net + CNT_W'(issue);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: per-cycle vector table plus
// hand-written redirect, stall, protocol-error and async-reset sequences.
module tb_fetch_prefetch_queue;

  localparam int DW    = 32;
  localparam int AB    = 32;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          redirect = 1'b0;
  logic [AB-1:0] program_address = '0;
  logic [AB-1:0] redirect_address = '0;
  logic [2:0]    occupancy;
  logic          protocol_error;

  fetch_prefetch_queue_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB)) bus ();

  fetch_prefetch_queue #(
    .DATA_WIDTH   (DW),
    .ADDRESS_BITS (AB),
    .DEPTH        (DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .program_address  (program_address),
    .redirect         (redirect),
    .redirect_address (redirect_address),
    .bus              (bus.master),
    .occupancy        (occupancy),
    .protocol_error   (protocol_error)
  );

  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [AB-1:0] addr;
    int            due;
  } req_t;

  typedef struct {
    bit            rst;
    bit            start;
    logic [AB-1:0] pa;
    bit            fr;
    bit            imr;
    bit            e_read;
    logic [AB-1:0] e_addr;
    bit            e_fv;
    logic [AB-1:0] e_pc;
    logic [2:0]    e_occ;
  } vec_t;

  req_t pend[$];
  vec_t vecs[$];
  int   cyc = 0;
  int   mem_lat = 1;
  bit   auto_mem = 1'b1;
  bit   corrupt = 1'b0;

  function automatic logic [DW-1:0] instr_of(input logic [AB-1:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input bit rst, input bit st, input logic [AB-1:0] pa, input bit fr,
                     input bit imr, input bit e_read, input logic [AB-1:0] e_addr,
                     input bit e_fv, input logic [AB-1:0] e_pc, input logic [2:0] e_occ);
    vec_t v;
    v = '{rst, st, pa, fr, imr, e_read, e_addr, e_fv, e_pc, e_occ};
    vecs.push_back(v);
  endtask

  // One clock: log any issued request, advance, then play the memory model.
  task automatic cycle();
    req_t r;
    #1;
    check("no_overflow", 64'(occupancy <= 3'd4), 64'd1);
    if (bus.i_mem_read === 1'b1 && bus.i_mem_ready) begin
      r.addr = bus.i_mem_address_in;
      r.due  = cyc + 1 + mem_lat;
      pend.push_back(r);
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (auto_mem) begin
      bus.i_mem_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        r = pend.pop_front();
        bus.i_mem_valid       = 1'b1;
        bus.i_mem_address_out = corrupt ? (r.addr ^ 32'h40) : r.addr;
        bus.i_mem_data_out    = instr_of(r.addr);
        corrupt = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    redirect = 1'b0;
    bus.fetch_ready = 1'b0;
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b0;
    bus.i_mem_address_out = '0;
    bus.i_mem_data_out = '0;
    pend.delete();
    auto_mem = 1'b1;
    corrupt = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [AB-1:0] stall_pc [2];

    // rst start pa fr imr | read addr fv pc occ
    add(1, 1, 32'h100, 1, 1,  0, 32'h000, 0, 32'h000, 3'd0);
    add(0, 0, 32'h100, 1, 1,  1, 32'h100, 0, 32'h000, 3'd0);
    add(0, 0, 32'h100, 1, 1,  1, 32'h104, 0, 32'h000, 3'd0);
    add(0, 0, 32'h100, 1, 1,  1, 32'h108, 1, 32'h100, 3'd1);
    add(0, 0, 32'h100, 1, 1,  1, 32'h10C, 1, 32'h104, 3'd1);
    add(0, 0, 32'h100, 1, 1,  1, 32'h110, 1, 32'h108, 3'd1);
    add(0, 0, 32'h100, 1, 1,  1, 32'h114, 1, 32'h10C, 3'd1);
    add(1, 1, 32'h100, 0, 1,  0, 32'h000, 0, 32'h000, 3'd0);
    add(0, 0, 32'h100, 0, 1,  1, 32'h100, 0, 32'h000, 3'd0);
    add(0, 0, 32'h100, 0, 1,  1, 32'h104, 0, 32'h000, 3'd0);
    add(0, 0, 32'h100, 0, 1,  1, 32'h108, 1, 32'h100, 3'd1);
    add(0, 0, 32'h100, 0, 1,  1, 32'h10C, 1, 32'h100, 3'd2);
    add(0, 0, 32'h100, 0, 1,  0, 32'h110, 1, 32'h100, 3'd3);
    add(0, 0, 32'h100, 0, 1,  0, 32'h110, 1, 32'h100, 3'd4);
    add(0, 0, 32'h100, 1, 1,  0, 32'h110, 1, 32'h100, 3'd4);
    add(0, 0, 32'h100, 1, 1,  1, 32'h110, 1, 32'h104, 3'd3);
    add(0, 0, 32'h100, 1, 1,  1, 32'h114, 1, 32'h108, 3'd2);
    add(0, 0, 32'h100, 1, 1,  1, 32'h118, 1, 32'h10C, 3'd2);
    add(0, 0, 32'h100, 1, 1,  1, 32'h11C, 1, 32'h110, 3'd2);

    do_reset();
    #1;
    check("reset_fetch_valid", bus.fetch_valid, 0);
    check("reset_i_mem_read", bus.i_mem_read, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_protocol_error", protocol_error, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      start           = vecs[i].start;
      program_address = vecs[i].pa;
      bus.fetch_ready = vecs[i].fr;
      bus.i_mem_ready = vecs[i].imr;
      #1;
      check($sformatf("v%0d_i_mem_read", i), bus.i_mem_read, vecs[i].e_read);
      check($sformatf("v%0d_i_mem_address_in", i), bus.i_mem_address_in, vecs[i].e_addr);
      check($sformatf("v%0d_fetch_valid", i), bus.fetch_valid, vecs[i].e_fv);
      check($sformatf("v%0d_fetch_pc", i), bus.fetch_pc, vecs[i].e_pc);
      check($sformatf("v%0d_fetch_instruction", i), bus.fetch_instruction,
            vecs[i].e_fv ? instr_of(vecs[i].e_pc) : 32'h0);
      check($sformatf("v%0d_occupancy", i), occupancy, vecs[i].e_occ);
      check($sformatf("v%0d_protocol_error", i), protocol_error, 0);
      cycle();
    end

    // Redirect with two requests in flight and one entry buffered.
    do_reset();
    mem_lat = 3;
    start = 1'b1; program_address = 32'h100; bus.i_mem_ready = 1'b1; bus.fetch_ready = 1'b0;
    cycle();
    start = 1'b0;
    #1; check("redir_first_read", bus.i_mem_read, 1);
    cycle();
    bus.i_mem_ready = 1'b0;
    cycle();
    cycle();
    bus.i_mem_ready = 1'b1;
    #1; check("redir_resume_addr", bus.i_mem_address_in, 32'h104);
    cycle();
    cycle();
    redirect = 1'b1; redirect_address = 32'h203; bus.fetch_ready = 1'b1;
    #1;
    check("redir_no_issue", bus.i_mem_read, 0);
    check("redir_head_before", bus.fetch_pc, 32'h100);
    check("redir_occ_before", occupancy, 1);
    cycle();
    redirect = 1'b0;
    #1;
    check("redir_flushed_occ", occupancy, 0);
    check("redir_flushed_valid", bus.fetch_valid, 0);
    check("redir_new_read", bus.i_mem_read, 1);
    check("redir_new_addr", bus.i_mem_address_in, 32'h200);
    cycle();
    for (int k = 0; k < 3; k++) begin
      #1; check($sformatf("redir_stale_dropped_%0d", k), bus.fetch_valid, 0);
      cycle();
    end
    #1;
    check("redir_first_valid", bus.fetch_valid, 1);
    check("redir_first_pc", bus.fetch_pc, 32'h200);
    check("redir_first_instr", bus.fetch_instruction, instr_of(32'h200));
    check("redir_no_error", protocol_error, 0);

    // Memory not ready for five cycles: address held, nothing lost.
    do_reset();
    mem_lat = 1;
    stall_pc[0] = 32'h100; stall_pc[1] = 32'h104;
    start = 1'b1; program_address = 32'h100; bus.i_mem_ready = 1'b1; bus.fetch_ready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    bus.i_mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall_read_%0d", k), bus.i_mem_read, 0);
      check($sformatf("stall_addr_%0d", k), bus.i_mem_address_in, 32'h108);
      if (k < 2) check($sformatf("stall_pc_%0d", k), bus.fetch_pc, stall_pc[k]);
      cycle();
    end
    bus.i_mem_ready = 1'b1;
    #1;
    check("stall_resume_read", bus.i_mem_read, 1);
    check("stall_resume_addr", bus.i_mem_address_in, 32'h108);
    cycle();
    #1; check("stall_empty", bus.fetch_valid, 0);
    cycle();
    #1;
    check("stall_resume_pc", bus.fetch_pc, 32'h108);
    check("stall_resume_instr", bus.fetch_instruction, instr_of(32'h108));

    // Spurious response with nothing outstanding.
    do_reset();
    start = 1'b1; program_address = 32'h100; bus.i_mem_ready = 1'b0; bus.fetch_ready = 1'b0;
    cycle();
    start = 1'b0;
    cycle();
    auto_mem = 1'b0;
    bus.i_mem_valid = 1'b1; bus.i_mem_address_out = 32'h100; bus.i_mem_data_out = 32'h1234;
    #1; check("spur_err_before", protocol_error, 0);
    cycle();
    bus.i_mem_valid = 1'b0;
    #1;
    check("spur_err_set", protocol_error, 1);
    check("spur_no_push", occupancy, 0);
    repeat (3) cycle();
    #1; check("spur_err_sticky", protocol_error, 1);
    do_reset();
    #1; check("spur_err_cleared", protocol_error, 0);

    // Response carrying the wrong address.
    start = 1'b1; program_address = 32'h100; bus.i_mem_ready = 1'b1; bus.fetch_ready = 1'b1;
    cycle();
    start = 1'b0;
    corrupt = 1'b1;
    cycle();
    bus.i_mem_ready = 1'b0;
    #1;
    check("badaddr_err_before", protocol_error, 0);
    check("badaddr_seen", bus.i_mem_address_out, 32'h140);
    cycle();
    #1;
    check("badaddr_err_set", protocol_error, 1);
    check("badaddr_no_push", bus.fetch_valid, 0);
    check("badaddr_occ", occupancy, 0);

    // Asynchronous reset with a full queue.
    do_reset();
    start = 1'b1; program_address = 32'h100; bus.i_mem_ready = 1'b1; bus.fetch_ready = 1'b0;
    cycle();
    start = 1'b0;
    repeat (6) cycle();
    #1;
    check("full_occ", occupancy, 4);
    check("full_valid", bus.fetch_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_fetch_valid", bus.fetch_valid, 0);
    check("async_fetch_instr", bus.fetch_instruction, 0);
    check("async_fetch_pc", bus.fetch_pc, 0);
    check("async_read", bus.i_mem_read, 0);
    check("async_addr_in", bus.i_mem_address_in, 0);
    check("async_occupancy", occupancy, 0);
    check("async_protocol_error", protocol_error, 0);
    @(negedge clock);
    pend.delete();
    bus.i_mem_valid = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("idle_no_read_%0d", k), bus.i_mem_read, 0);
      check($sformatf("idle_no_valid_%0d", k), bus.fetch_valid, 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

endmodule
